// File: rtl/counter_mon_pkg.sv
// Package: counter_mon_pkg
// Purpose : Shared defaults and helpers for the counter wrap monitor.
//   CW_DEF         width of the observed count
//   WCW_DEF        width of the wrap total / event payload
//   FIFO_DEPTH_DEF event FIFO entries (power of 2, >= 2)
//   CNT_MAX        terminal value of the default-width count
//   lvl_w()        width of an occupancy value 0..depth
package counter_mon_pkg;

  localparam int CW_DEF         = 4;
  localparam int WCW_DEF        = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  localparam logic [CW_DEF-1:0] CNT_MAX = '1;

  // Occupancy must represent 0..depth inclusive, hence one bit more than the address.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/counter_evt_fifo.sv
// Module : counter_evt_fifo
// Purpose: Synchronous FIFO holding wrap events (W bits x DEPTH entries).
// Ports  :
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset; empties FIFO and zeroes storage
//   push   in   write wdata (ignored when full unless a pop happens on the same edge)
//   pop    in   drop the head entry (ignored when empty)
//   wdata  in   [W-1:0] data to write
//   rdata  out  [W-1:0] head entry
//   full   out  occupancy == DEPTH
//   empty  out  occupancy == 0
//   level  out  [LW-1:0] occupancy 0..DEPTH
module counter_evt_fifo
  import counter_mon_pkg::*;
#(
  parameter  int W     = WCW_DEF,
  parameter  int DEPTH = FIFO_DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = lvl_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == DEPTH[LW-1:0]);
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_wrap_monitor.sv
// Module : counter_wrap_monitor
// Purpose: Watches an upstream counter, detects max->0 wraps, keeps a running wrap
//          total and queues each wrap as an event on a valid/ready stream.
//          Optional macro COUNTER_MON_STEPCHK_EN adds a +1-per-clock step checker.
// Ports  :
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset; clears all state
//   cnt_in     in   [CW-1:0] registered count from the upstream counter
//   cnt_clr    in   upstream counter is being cleared; suppresses detection
//   evt_valid  out  event FIFO non-empty
//   evt_ready  in   consumer ready for the head event
//   evt_data   out  [WCW-1:0] wrap total captured at the head event's wrap
//   wrap_total out  [WCW-1:0] wraps since reset, modulo 2^WCW
//   fifo_level out  [LW-1:0] event FIFO occupancy
//   overflow   out  sticky: a wrap event was dropped because the FIFO was full
//   step_err   out  sticky: illegal count step (0 when the step checker is absent)
//
// Event stream: a beat transfers on a rising edge where evt_valid & evt_ready are both
// high; evt_data is held stable while evt_valid is high and evt_ready is low.
module counter_wrap_monitor
  import counter_mon_pkg::*;
#(
  parameter  int CW         = CW_DEF,
  parameter  int WCW        = WCW_DEF,
  parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int LW         = lvl_w(FIFO_DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [CW-1:0]  cnt_in,
  input  logic           cnt_clr,
  output logic           evt_valid,
  input  logic           evt_ready,
  output logic [WCW-1:0] evt_data,
  output logic [WCW-1:0] wrap_total,
  output logic [LW-1:0]  fifo_level,
  output logic           overflow,
  output logic           step_err
);

  localparam logic [CW-1:0] CNT_TOP = '1;

  logic [CW-1:0]  cnt_q;
  // base_vld: previous sample was taken outside a clear, so (cnt_q, cnt_in) is a real step.
  logic           base_vld;
  logic [WCW-1:0] wrap_total_q;
  logic [WCW-1:0] wrap_nxt;
  logic           wrap_hit;
  logic           overflow_q;
  logic           fifo_full;
  logic           fifo_empty;
  logic           pop_fire;

  assign wrap_hit  = base_vld & ~cnt_clr & (cnt_q == CNT_TOP) & (cnt_in == '0);
  assign wrap_nxt  = wrap_total_q + 1'b1;
  assign evt_valid = ~fifo_empty;
  assign pop_fire  = evt_valid & evt_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      base_vld     <= 1'b0;
      wrap_total_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_in;
      base_vld <= ~cnt_clr;
      if (wrap_hit) begin
        wrap_total_q <= wrap_nxt;
        // The total keeps counting even when the event itself is dropped.
        if (fifo_full && !pop_fire) begin
          overflow_q <= 1'b1;
        end
      end
    end
  end

  counter_evt_fifo #(
    .W     (WCW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (wrap_hit),
    .pop   (pop_fire),
    .wdata (wrap_nxt),
    .rdata (evt_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign wrap_total = wrap_total_q;
  assign overflow   = overflow_q;

`ifdef COUNTER_MON_STEPCHK_EN
  logic          step_err_q;
  logic [CW-1:0] cnt_exp;

  // Modulo-2^CW increment, so max->0 is a legal step; a hold is not.
  assign cnt_exp = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_err_q <= 1'b0;
    end else if (base_vld && !cnt_clr && (cnt_in != cnt_exp)) begin
      step_err_q <= 1'b1;
    end
  end

  assign step_err = step_err_q;
`else
  assign step_err = 1'b0;
`endif

endmodule

// File: tb/tb_counter_wrap_monitor.sv
// Testbench: tb_counter_wrap_monitor
// Directed stimulus for counter_wrap_monitor, with a small reference model and an
// expected-event queue. Step-check expectations follow COUNTER_MON_STEPCHK_EN.
module tb_counter_wrap_monitor;
  import counter_mon_pkg::*;

  localparam int CW  = 4;
  localparam int WCW = 8;
  localparam int D   = 4;
  localparam int LW  = 3;
`ifdef COUNTER_MON_STEPCHK_EN
  localparam bit STEPCHK = 1'b1;
`else
  localparam bit STEPCHK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           reset;
  logic [CW-1:0]  cnt_in;
  logic           cnt_clr;
  logic           evt_valid;
  logic           evt_ready;
  logic [WCW-1:0] evt_data;
  logic [WCW-1:0] wrap_total;
  logic [LW-1:0]  fifo_level;
  logic           overflow;
  logic           step_err;

  always #50 clk = ~clk;

  counter_wrap_monitor dut (
    .clk        (clk),
    .reset      (reset),
    .cnt_in     (cnt_in),
    .cnt_clr    (cnt_clr),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_data   (evt_data),
    .wrap_total (wrap_total),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .step_err   (step_err)
  );

  // ---------------- scoreboard ----------------
  int             pass_cnt  = 0;
  int             total_cnt = 0;
  logic [WCW-1:0] exp_q[$];
  logic [CW-1:0]  m_cnt_q;
  logic           m_base;
  logic [WCW-1:0] m_wt;
  logic           m_ovf;
  logic           m_serr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    m_cnt_q = '0;
    m_base  = 1'b0;
    m_wt    = '0;
    m_ovf   = 1'b0;
    m_serr  = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // Apply one count sample, advance one clock, then compare against the model.
  task automatic cyc(input logic [CW-1:0] v, input logic clr);
    logic          hit;
    logic          pop;
    logic [CW-1:0] nxt;
    cnt_in  = v;
    cnt_clr = clr;
    nxt = m_cnt_q + 1'b1;
    hit = m_base & ~clr & (m_cnt_q == 4'hF) & (v == 4'h0);
    pop = (exp_q.size() != 0) & evt_ready;
    if (pop) begin
      check("evt_data_pop", evt_data, exp_q[0]);
      void'(exp_q.pop_front());
    end
    if (hit) begin
      m_wt++;
      if (exp_q.size() < D) exp_q.push_back(m_wt);
      else m_ovf = 1'b1;
    end
    if (STEPCHK && m_base && !clr && (v != nxt)) m_serr = 1'b1;
    m_cnt_q = v;
    m_base  = ~clr;
    @(posedge clk);
    #1;
    check("fifo_level", fifo_level, exp_q.size());
    check("evt_valid", evt_valid, exp_q.size() != 0);
    check("wrap_total", wrap_total, m_wt);
    check("overflow", overflow, m_ovf);
    check("step_err", step_err, m_serr);
    if (exp_q.size() != 0) check("evt_data_head", evt_data, exp_q[0]);
  endtask

  task automatic run_wrap();
    for (int i = 1; i < 16; i++) cyc(CW'(i), 1'b0);
    cyc(4'h0, 1'b0);
  endtask

  // Reset is asserted away from any clock edge; outputs must clear without a clock.
  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b0;
    cnt_clr = 1'b1;
    cnt_in  = '0;
    model_clear();
    #10;
    check("rst_level", fifo_level, 0);
    check("rst_valid", evt_valid, 0);
    check("rst_data", evt_data, 0);
    check("rst_total", wrap_total, 0);
    check("rst_ovf", overflow, 0);
    check("rst_serr", step_err, 0);
    @(negedge clk);
    reset = 1'b1;
    cyc(4'h0, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset     = 1'b0;
    cnt_clr   = 1'b1;
    cnt_in    = '0;
    evt_ready = 1'b0;
    model_clear();

    // 1: reset low for 500, then clear held; a 15->0 pattern under clear is ignored
    #490;
    check("t1_rst_valid", evt_valid, 0);
    check("t1_rst_total", wrap_total, 0);
    check("t1_rst_level", fifo_level, 0);
    check("t1_rst_data", evt_data, 0);
    #10;
    reset = 1'b1;
    cyc(4'hE, 1'b1);
    cyc(4'hF, 1'b1);
    cyc(4'h0, 1'b1);
    cyc(4'hF, 1'b1);
    cyc(4'h0, 1'b1);
    check("t1_clr_valid", evt_valid, 0);
    check("t1_clr_total", wrap_total, 0);

    // 2: free count with ready high
    evt_ready = 1'b1;
    run_wrap();
    check("t2_first_valid", evt_valid, 1);
    check("t2_first_data", evt_data, 1);
    check("t2_first_total", wrap_total, 1);
    run_wrap();
    run_wrap();
    check("t2_total3", wrap_total, 3);
    check("t2_data3", evt_data, 3);

    // 3: consumer stalled for 5 wraps, then drains in order
    do_reset();
    evt_ready = 1'b0;
    repeat (5) run_wrap();
    check("t3_level", fifo_level, 4);
    check("t3_head", evt_data, 1);
    check("t3_ovf", overflow, 1);
    check("t3_total", wrap_total, 5);
    evt_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("t3_pop_order", evt_data, k);
      cyc(CW'(k), 1'b0);
    end
    check("t3_drained", fifo_level, 0);
    check("t3_drained_valid", evt_valid, 0);

    // 4: full FIFO, wrap and pop on the same edge
    do_reset();
    evt_ready = 1'b0;
    repeat (4) run_wrap();
    check("t4_full", fifo_level, 4);
    for (int i = 1; i < 16; i++) cyc(CW'(i), 1'b0);
    evt_ready = 1'b1;
    cyc(4'h0, 1'b0);
    check("t4_level", fifo_level, 4);
    check("t4_ovf", overflow, 0);
    check("t4_head", evt_data, 2);
    check("t4_total", wrap_total, 5);
    evt_ready = 1'b0;
    cyc(4'h0, 1'b1);
    check("t4_clr_total", wrap_total, 5);
    check("t4_clr_level", fifo_level, 4);

    // 5: step checking
    do_reset();
    cyc(4'h3, 1'b0);
    cyc(4'h4, 1'b0);
    check("t5_step_ok", step_err, 0);
    cyc(4'h6, 1'b0);
    check("t5_skip", step_err, STEPCHK);
    do_reset();
    cyc(4'h6, 1'b0);
    cyc(4'h7, 1'b0);
    cyc(4'h7, 1'b0);
    check("t5_hold", step_err, STEPCHK);
    do_reset();
    cyc(4'hE, 1'b0);
    cyc(4'hF, 1'b0);
    cyc(4'h0, 1'b0);
    check("t5_wrap_ok", step_err, 0);
    do_reset();
    cyc(4'h8, 1'b0);
    cyc(4'h9, 1'b0);
    cyc(4'h0, 1'b1);
    cyc(4'h0, 1'b0);
    cyc(4'h1, 1'b0);
    check("t5_clr_ok", step_err, 0);

    // 6: reset with three events queued
    do_reset();
    evt_ready = 1'b0;
    repeat (3) run_wrap();
    check("t6_level3", fifo_level, 3);
    do_reset();
    check("t6_after_total", wrap_total, 0);
    check("t6_after_level", fifo_level, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
